// File: rtl/flip_flop_pkg.sv
// Shared opcodes and FSM state encoding for the JK flop-bank driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flip_flop_pkg;

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_CLEAR  = 2'd1;
    localparam logic [1:0] OP_SET    = 2'd2;
    localparam logic [1:0] OP_TOGGLE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/jk_excite_enc.sv
// Maps a bank-update opcode onto per-bit J/K/CE excitation for a JK flop bank.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module jk_excite_enc
    import flip_flop_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_snap,
    input  logic [WIDTH-1:0] exp_val,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] ce
);

    // LOAD enables only the bits that differ from the snapshot; CLEAR/SET use
    // the broadcast R/S lines so J/K/CE stay quiet; TOGGLE uses J=K=1 per bit.
    always_comb begin
        j  = '0;
        k  = '0;
        ce = '0;
        case (op)
            OP_LOAD: begin
                j  = exp_val;
                k  = ~exp_val;
                ce = q_snap ^ exp_val;
            end
            OP_TOGGLE: begin
                j  = data;
                k  = data;
                ce = data;
            end
            default: begin
                j  = '0;
                k  = '0;
                ce = '0;
            end
        endcase
    end

endmodule

// File: rtl/flip_flop_jk_driver.sv
// Command front end that drives a JK flop bank, reads Q back and retries on mismatch.
// Latency: accept t0, DRIVE t1, CHECK t2, done/err t3 (+2 per retry, +SETTLE per attempt).
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored.
module flip_flop_jk_driver
    import flip_flop_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2,
    parameter int SETTLE    = 0
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] CE,
    output logic             ff_s,
    output logic             ff_r,
    input  logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Counter widths never drop to zero so MAX_RETRY=0 / SETTLE<=1 stay legal.
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] qsnap_q;
    logic [RW-1:0]    retry_q;
    logic [SW-1:0]    settle_q;
    logic             redrive_q;   // current DRIVE is a retry: always LOAD-style
    logic             pass_q;      // outcome of the last CHECK, shown in FIN

    logic             accept;
    logic             check_ok;
    logic             can_retry;
    logic [WIDTH-1:0] exp_nxt;
    logic [1:0]       enc_op;
    logic [WIDTH-1:0] enc_j, enc_k, enc_ce;

    assign cmd_ready = (state == ST_IDLE) && !R;
    assign accept    = cmd_valid && cmd_ready;
    assign check_ok  = (Q == exp_q);
    assign can_retry = (retry_q < RW'(MAX_RETRY));
    assign enc_op    = redrive_q ? OP_LOAD : op_q;

    // Target bank value for the incoming command; TOGGLE uses Q at the accept edge.
    always_comb begin
        exp_nxt = '0;
        case (cmd_op)
            OP_LOAD:   exp_nxt = cmd_data;
            OP_CLEAR:  exp_nxt = '0;
            OP_SET:    exp_nxt = '1;
            OP_TOGGLE: exp_nxt = Q ^ cmd_data;
            default:   exp_nxt = '0;
        endcase
    end

    jk_excite_enc #(.WIDTH(WIDTH)) u_enc (
        .q_snap  (qsnap_q),
        .exp_val (exp_q),
        .op      (enc_op),
        .data    (data_q),
        .j       (enc_j),
        .k       (enc_k),
        .ce      (enc_ce)
    );

    // Next-state logic for the command sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_DRIVE;
            ST_DRIVE:  state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
            ST_SETTLE: if (int'(settle_q) >= SETTLE - 1) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (check_ok)       state_nxt = ST_FIN;
                else if (can_retry) state_nxt = ST_DRIVE;
                else                state_nxt = ST_FIN;
            end
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Bank drive and status outputs; excitation is only ever nonzero in DRIVE.
    always_comb begin
        J    = '0;
        K    = '0;
        CE   = '0;
        ff_s = 1'b0;
        ff_r = 1'b0;
        busy = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
        done = (state == ST_FIN) && pass_q;
        err  = (state == ST_FIN) && !pass_q;
        if (state == ST_DRIVE) begin
            J    = enc_j;
            K    = enc_k;
            CE   = enc_ce;
            ff_r = !redrive_q && (op_q == OP_CLEAR);
            ff_s = !redrive_q && (op_q == OP_SET);
        end
    end

    // State register plus command, snapshot, retry and settle bookkeeping.
    always_ff @(posedge Clk) begin
        if (R) begin
            state     <= ST_IDLE;
            op_q      <= OP_LOAD;
            data_q    <= '0;
            exp_q     <= '0;
            qsnap_q   <= '0;
            retry_q   <= '0;
            settle_q  <= '0;
            redrive_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q      <= cmd_op;
                data_q    <= cmd_data;
                exp_q     <= exp_nxt;
                qsnap_q   <= Q;
                retry_q   <= '0;
                redrive_q <= 1'b0;
            end
            if (state == ST_CHECK) begin
                pass_q <= check_ok;
                if (!check_ok && can_retry) begin
                    retry_q   <= retry_q + 1'b1;
                    redrive_q <= 1'b1;
                    qsnap_q   <= Q;
                end
            end
            if (state == ST_DRIVE) begin
                settle_q <= '0;
            end else if (state == ST_SETTLE) begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flip_flop_jk_driver.sv
// Directed bench for the JK flop-bank driver with a behavioural bank model.
// Latency: n/a.
// Backpressure: n/a.
module tb_flip_flop_jk_driver;
    import flip_flop_pkg::*;

    logic       Clk;
    logic       R;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] J, K, CE, Q;
    logic       ff_s, ff_r, busy, done, err;

    logic [7:0] bank_q;
    logic [7:0] stuck0;
    logic [7:0] preload_val;
    logic       preload_en;

    int n_chk;
    int n_pass;

    flip_flop_jk_driver #(.WIDTH(8), .MAX_RETRY(2), .SETTLE(0)) dut (
        .Clk       (Clk),
        .R         (R),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .J         (J),
        .K         (K),
        .CE        (CE),
        .ff_s      (ff_s),
        .ff_r      (ff_r),
        .Q         (Q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign Q = bank_q;

    // JK bank: R over S over CE, with an optional stuck-at-0 mask.
    always @(posedge Clk) begin : bank_model
        logic [7:0] nq;
        nq = bank_q;
        if (preload_en) begin
            nq = preload_val;
        end else if (ff_r) begin
            nq = 8'h00;
        end else if (ff_s) begin
            nq = 8'hFF;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (CE[i]) begin
                    if (J[i] && K[i]) nq[i] = ~bank_q[i];
                    else if (J[i])    nq[i] = 1'b1;
                    else if (K[i])    nq[i] = 1'b0;
                end
            end
            nq = nq & ~stuck0;
        end
        bank_q <= nq;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    endtask

    task automatic cyc();
        @(negedge Clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] v);
        preload_val = v;
        preload_en  = 1'b1;
        cyc();
        preload_en  = 1'b0;
    endtask

    // Present one command in the current IDLE cycle; returns in the DRIVE cycle.
    task automatic send(input logic [1:0] op, input logic [7:0] d);
        check("send_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic check_fin_done(input string tag);
        check({tag, "_done"},  {31'd0, done},      32'd1);
        check({tag, "_err"},   {31'd0, err},       32'd0);
        check({tag, "_busy"},  {31'd0, busy},      32'd0);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd0);
    endtask

    initial begin
        int drives, dones, errs, accepts, last_acc;
        logic [7:0] acc_dat;
        logic       pend_drive;
        logic       seen_end;

        n_chk = 0;
        n_pass = 0;
        R = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = OP_LOAD;
        cmd_data = 8'h00;
        preload_en = 1'b0;
        preload_val = 8'h00;
        stuck0 = 8'h00;

        // Reset state
        repeat (3) cyc();
        check("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_jkce",  {8'd0, J, K, CE},   32'd0);
        check("rst_flags", {27'd0, ff_s, ff_r, done, err, busy}, 32'd0);
        R = 1'b0;
        #1;
        check("rst_ready_rel", {31'd0, cmd_ready}, 32'd1);

        // LOAD 0xA5 from 0x0F
        preload(8'h0F);
        send(OP_LOAD, 8'hA5);
        check("ld_j",    {24'd0, J},  32'hA5);
        check("ld_k",    {24'd0, K},  32'h5A);
        check("ld_ce",   {24'd0, CE}, 32'hAA);
        check("ld_busy", {31'd0, busy}, 32'd1);
        check("ld_rs",   {30'd0, ff_s, ff_r}, 32'd0);
        cyc();
        check("ld_chk_q",    {24'd0, Q}, 32'hA5);
        check("ld_chk_jkce", {8'd0, J, K, CE}, 32'd0);
        check("ld_chk_done", {31'd0, done}, 32'd0);
        cyc();
        check_fin_done("ld_fin");
        cyc();
        check("ld_idle_done",  {31'd0, done},      32'd0);
        check("ld_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // TOGGLE 0x81 from 0x3C
        preload(8'h3C);
        send(OP_TOGGLE, 8'h81);
        check("tg_jkce", {8'd0, J, K, CE}, {8'd0, 8'h81, 8'h81, 8'h81});
        cyc();
        check("tg_q", {24'd0, Q}, 32'hBD);
        cyc();
        check_fin_done("tg_fin");
        cyc();

        // CLEAR from 0xFF, then SET
        preload(8'hFF);
        send(OP_CLEAR, 8'h5A);
        check("clr_r",    {31'd0, ff_r}, 32'd1);
        check("clr_s",    {31'd0, ff_s}, 32'd0);
        check("clr_jkce", {8'd0, J, K, CE}, 32'd0);
        cyc();
        check("clr_r_off", {31'd0, ff_r}, 32'd0);
        check("clr_q",     {24'd0, Q}, 32'h00);
        cyc();
        check_fin_done("clr_fin");
        cyc();
        send(OP_SET, 8'h00);
        check("set_s",    {31'd0, ff_s}, 32'd1);
        check("set_r",    {31'd0, ff_r}, 32'd0);
        check("set_jkce", {8'd0, J, K, CE}, 32'd0);
        cyc();
        check("set_s_off", {31'd0, ff_s}, 32'd0);
        check("set_q",     {24'd0, Q}, 32'hFF);
        cyc();
        check_fin_done("set_fin");
        cyc();

        // Bit 3 stuck low: initial drive + 2 retries, then err
        preload(8'h00);
        stuck0 = 8'h08;
        send(OP_LOAD, 8'h08);
        drives = 0; dones = 0; errs = 0; seen_end = 1'b0;
        for (int c = 0; c < 20 && !seen_end; c++) begin
            if (J == 8'h08 && K == 8'hF7 && CE == 8'h08) drives++;
            if (done) begin dones++; seen_end = 1'b1; end
            if (err)  begin errs++;  seen_end = 1'b1; end
            if (!seen_end) cyc();
        end
        check("stk_drives", drives, 32'd3);
        check("stk_err",    errs,   32'd1);
        check("stk_done",   dones,  32'd0);
        check("stk_fin_ready", {31'd0, cmd_ready}, 32'd0);
        cyc();
        send(OP_LOAD, 8'h01);
        cyc();
        check("stk_next_q", {24'd0, Q}, 32'h01);
        cyc();
        check_fin_done("stk_next_fin");
        cyc();
        stuck0 = 8'h00;

        // Reset asserted in DRIVE aborts silently
        preload(8'h00);
        send(OP_LOAD, 8'h55);
        check("ab_drive_j", {24'd0, J}, 32'h55);
        R = 1'b1;
        cyc();
        check("ab_jkce",  {8'd0, J, K, CE}, 32'd0);
        check("ab_flags", {27'd0, ff_s, ff_r, done, err, busy}, 32'd0);
        check("ab_ready_in_r", {31'd0, cmd_ready}, 32'd0);
        R = 1'b0;
        #1;
        check("ab_ready_rel", {31'd0, cmd_ready}, 32'd1);
        dones = 0; errs = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dones++;
            if (err)  errs++;
            cyc();
        end
        check("ab_no_pulse", dones + errs, 32'd0);

        // cmd_valid held high: accepts every 4 cycles, busy-time data ignored
        cmd_valid = 1'b1;
        cmd_op = OP_LOAD;
        accepts = 0; last_acc = -1; pend_drive = 1'b0; acc_dat = 8'h00;
        for (int i = 0; i < 13; i++) begin
            cmd_data = 8'h10 + 8'(i);
            if (pend_drive) begin
                check("bb_drive_j", {24'd0, J}, {24'd0, acc_dat});
                pend_drive = 1'b0;
            end
            if (done) check("bb_fin_ready", {31'd0, cmd_ready}, 32'd0);
            if (cmd_ready) begin
                if (last_acc >= 0) check("bb_spacing", i - last_acc, 32'd4);
                last_acc = i;
                accepts++;
                acc_dat = cmd_data;
                pend_drive = 1'b1;
            end
            cyc();
        end
        cmd_valid = 1'b0;
        check("bb_accepts", accepts, 32'd4);
        check("bb_last_j", {24'd0, J}, 32'h1C);
        repeat (4) cyc();
        check("bb_idle_ready", {31'd0, cmd_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/flip_flop_jk_driver.md
Name: flip_flop_jk_driver

Overview:
- Command-driven initiator for a bank of WIDTH JK flip-flops (each with sync R, sync S and CE, priority R > S > CE).
- Accepts a command over a valid/ready handshake and translates it into J/K/CE/set/reset drive for the bank.
- Reads back the bank's Q and confirms the result, retrying up to MAX_RETRY times.
- Used as the register-bank front end and as the self-checking driver in flop-bank benches.

Parameters:
- WIDTH, 8: number of JK flops in the driven bank.
- MAX_RETRY, 2: re-drive attempts after a readback mismatch before flagging an error.
- SETTLE, 0: extra wait cycles between the drive cycle and the readback compare.

Ports:
- Clk  in  1  clock; all logic on posedge.
- R  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  0=LOAD, 1=CLEAR, 2=SET, 3=TOGGLE.
- cmd_data  in  WIDTH  LOAD value, or TOGGLE bit mask; ignored for CLEAR and SET.
- J  out  WIDTH  per-bit J to the bank.
- K  out  WIDTH  per-bit K to the bank.
- CE  out  WIDTH  per-bit clock enable to the bank.
- ff_s  out  1  broadcast synchronous set to the bank.
- ff_r  out  1  broadcast synchronous reset to the bank.
- Q  in  WIDTH  bank outputs, read back.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse: command verified.
- err  out  1  one-cycle pulse: retries exhausted.

Behaviour:
- Reset (R=1 at a posedge, in any state, including mid-command):
  - Next state IDLE; J, K, CE, ff_s, ff_r, done, err, busy all become 0; retry and settle counters clear.
  - cmd_ready = (state==IDLE) && !R, so it is 0 in every cycle where R=1 and 1 from the first cycle after R drops.
- States: IDLE, DRIVE, SETTLE (skipped when SETTLE=0), CHECK, FIN.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid && cmd_ready and capture op and data.
  - Expected value: LOAD → data; CLEAR → 0; SET → all ones; TOGGLE → Q ^ data, using Q as sampled at the accept edge.
  - Next state DRIVE.
- DRIVE (exactly one cycle; drive outputs are nonzero only here, zero in every other state):
  - LOAD and every retry: J = exp, K = ~exp, CE = Q_snap ^ exp. Q_snap is Q registered at the edge entering DRIVE, so unchanged bits get CE=0.
  - CLEAR: ff_r=1; J=K=CE=0.
  - SET: ff_s=1; J=K=CE=0.
  - TOGGLE: J = K = CE = data.
  - Next state SETTLE, or CHECK when SETTLE=0.
- SETTLE: count SETTLE cycles, then go to CHECK.
- CHECK (one cycle): compare Q with exp.
  - Match → FIN with done.
  - Mismatch and retry < MAX_RETRY → retry++, then DRIVE using the LOAD-style encoding toward exp. A TOGGLE retry drives toward the original exp and does not re-toggle.
  - Mismatch and retry == MAX_RETRY → FIN with err.
- FIN: done or err is high for this one cycle; busy=0; next state IDLE.
  - cmd_ready is 0 in FIN, so back-to-back commands are spaced by one cycle.
- busy = 1 in DRIVE, SETTLE and CHECK.
- Latency (SETTLE=0, no retry):
  - Accept edge t0; DRIVE in cycle t1; CHECK in t2; done in t3; next accept possible at the end of t4.
  - Each retry adds 2 cycles; each SETTLE cycle adds 1 per attempt.
- done and err are never high together.
- cmd_valid while busy is ignored and does not stall internal progress.
- The retry counter uses clog2(MAX_RETRY+1) bits. MAX_RETRY=0 means no retry.
- Arbitrary WIDTH ≥ 1 is supported; all masks are WIDTH bits wide.

Decomposition:
- Shared package flip_flop_pkg holds:
  - Opcode constants OP_LOAD, OP_CLEAR, OP_SET, OP_TOGGLE.
  - The state encoding for this FSM.
- Sub-module jk_excite_enc: purely combinational; takes Q_snap, exp, op and data, returns J, K and CE. It is reused by the bench scoreboard.
- The FSM, counters and registers live in the top module.

Test Plan (WIDTH=8, MAX_RETRY=2, SETTLE=0, bench model of the JK bank attached):
- LOAD 0xA5 from Q=0x0F → DRIVE J=0xA5, K=0x5A, CE=0xAA; Q=0xA5 at CHECK; done pulse at t3; err=0.
- TOGGLE mask 0x81 from Q=0x3C → J=K=CE=0x81 in DRIVE; Q=0xBD; done.
- CLEAR from Q=0xFF → ff_r=1 for one cycle only, J=K=CE=0; Q=0x00; done. Then SET → ff_s one cycle; Q=0xFF; done.
- Bank model with bit 3 stuck at 0, LOAD 0x08 → three DRIVE cycles (the initial drive plus 2 retries), then err pulse, no done; the next command is accepted normally.
- R asserted during DRIVE of a LOAD → next cycle all outputs 0, state IDLE, cmd_ready=1 after R drops; no done or err ever pulses for the aborted command.
- cmd_valid held high continuously → accepts occur every 4 cycles; commands presented while busy are not captured; cmd_ready=0 in FIN.
